// File: rtl/codificador_op_if.sv
// rtl/codificador_op_if.sv - valid/ready op code channel from codificador_op to the op decoder
interface codificador_op_if #(
  parameter int OP_W = 2
);
  logic [OP_W-1:0] sal_op;
  logic            sal_valid;
  logic            sal_ready;

  modport master (output sal_op, output sal_valid, input sal_ready);
  modport slave  (input sal_op, input sal_valid, output sal_ready);
endinterface

// File: rtl/codificador_op.sv
// rtl/codificador_op.sv - one-hot request collector serving binary op codes on a valid/ready channel
// Fixed priority (bit 0 first) by default; define CODIFICADOR_ROUND_ROBIN_EN for rotating priority.
module codificador_op #(
  parameter int N_OP = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic [N_OP-1:0]   req_op,
  codificador_op_if.master  sal,
  output logic [N_OP-1:0]   pend,
  output logic              err_multi
);

  localparam int OP_W = $clog2(N_OP);

  localparam logic [0:0] VACIO   = 1'b0;
  localparam logic [0:0] OCUPADO = 1'b1;

  logic [0:0]      state_q, state_d;
  logic [OP_W-1:0] op_q, op_d;
  logic [N_OP-1:0] pend_q, pend_d;
  logic            err_q, err_d;
  logic [N_OP-1:0] grant;
  logic [OP_W-1:0] grant_idx;
  logic            slot_free;
  logic            multi_hot;

  assign slot_free = (state_q == VACIO) || sal.sal_ready;
  assign multi_hot = |(req_op & (req_op - {{(N_OP-1){1'b0}}, 1'b1}));

`ifdef CODIFICADOR_ROUND_ROBIN_EN
  logic [OP_W-1:0] ptr_q, ptr_d;

  // Search starts one past the last grant and wraps; power-of-2 N_OP makes the wrap a plain truncation.
  always_comb begin
    logic            found;
    logic [OP_W-1:0] idx;
    grant = '0;
    found = 1'b0;
    idx   = '0;
    if (en && slot_free) begin
      for (int k = 1; k <= N_OP; k++) begin
        idx = ptr_q + OP_W'(k);
        if (!found && pend_q[idx]) begin
          grant[idx] = 1'b1;
          found      = 1'b1;
        end
      end
    end
  end

  always_comb begin
    ptr_d = ptr_q;
    if (grant != '0) ptr_d = grant_idx;
  end

  always_ff @(posedge clk) begin
    if (rst) ptr_q <= OP_W'(N_OP - 1);
    else     ptr_q <= ptr_d;
  end
`else
  always_comb begin
    logic found;
    grant = '0;
    found = 1'b0;
    if (en && slot_free) begin
      for (int i = 0; i < N_OP; i++) begin
        if (!found && pend_q[i]) begin
          grant[i] = 1'b1;
          found    = 1'b1;
        end
      end
    end
  end
`endif

  always_comb begin
    grant_idx = '0;
    for (int i = 0; i < N_OP; i++) begin
      if (grant[i]) grant_idx = grant_idx | OP_W'(i);
    end
  end

  // A request on the bit being granted re-arms it, so nothing is lost.
  always_comb begin
    pend_d = pend_q;
    err_d  = err_q;
    if (en) begin
      pend_d = (pend_q & ~grant) | req_op;
      err_d  = err_q | multi_hot;
    end
  end

  // Accept and reload share one edge; a drop to VACIO only happens when nothing new is granted.
  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    if (grant != '0) begin
      state_d = OCUPADO;
      op_d    = grant_idx;
    end else if (state_q == OCUPADO && sal.sal_ready) begin
      state_d = VACIO;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= VACIO;
      op_q    <= '0;
      pend_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      pend_q  <= pend_d;
      err_q   <= err_d;
    end
  end

  assign sal.sal_op    = op_q;
  assign sal.sal_valid = (state_q == OCUPADO);
  assign pend          = pend_q;
  assign err_multi     = err_q;

endmodule

// File: tb/tb_codificador_op.sv
// tb/tb_codificador_op.sv - scoreboard bench for codificador_op
module tb_codificador_op;

  logic       clk;
  logic       rst;
  logic       en;
  logic [3:0] req_op;
  logic [3:0] pend;
  logic       err_multi;

  codificador_op_if #(.OP_W(2)) sal_if ();

  codificador_op #(.N_OP(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .en        (en),
    .req_op    (req_op),
    .sal       (sal_if),
    .pend      (pend),
    .err_multi (err_multi)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;
  logic [1:0] exp_q[$];
  logic [1:0] mon_exp;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Every handshake must match the next expected code in order.
  always @(negedge clk) begin
    if (!rst && sal_if.sal_valid && sal_if.sal_ready) begin
      if (exp_q.size() == 0) begin
        n_vec++;
        n_err++;
        $display("FAIL unexpected_code: got %0d expected none at %0t", sal_if.sal_op, $time);
      end else begin
        mon_exp = exp_q.pop_front();
        chk("code", {30'd0, sal_if.sal_op}, {30'd0, mon_exp});
      end
    end
  end

  initial begin
    rst = 1'b1;
    en = 1'b0;
    req_op = 4'b0000;
    sal_if.sal_ready = 1'b0;
    step();
    step();
    rst = 1'b0;
    chk("rst_pend", {28'd0, pend}, 32'd0);
    chk("rst_valid", {31'd0, sal_if.sal_valid}, 32'd0);
    chk("rst_op", {30'd0, sal_if.sal_op}, 32'd0);
    chk("rst_err", {31'd0, err_multi}, 32'd0);

    // Basic encode: op 2, two-cycle latency
    en = 1'b1;
    sal_if.sal_ready = 1'b1;
    exp_q.push_back(2'd2);
    req_op = 4'b0100;
    step();
    req_op = 4'b0000;
    chk("t1_pend_set", {28'd0, pend}, 32'h4);
    chk("t1_valid_early", {31'd0, sal_if.sal_valid}, 32'd0);
    step();
    chk("t1_valid", {31'd0, sal_if.sal_valid}, 32'd1);
    chk("t1_op", {30'd0, sal_if.sal_op}, 32'd2);
    step();
    chk("t1_valid_drop", {31'd0, sal_if.sal_valid}, 32'd0);
    chk("t1_pend_clr", {28'd0, pend}, 32'd0);
    chk("t1_err", {31'd0, err_multi}, 32'd0);

    // Priority with backpressure: ops 0,1,3 queued
    sal_if.sal_ready = 1'b0;
    exp_q.push_back(2'd0);
    exp_q.push_back(2'd1);
    exp_q.push_back(2'd3);
    req_op = 4'b0001;
    step();
    req_op = 4'b0010;
    step();
    req_op = 4'b1000;
    step();
    req_op = 4'b0000;
    chk("t2_pend", {28'd0, pend}, 32'hA);
    for (int i = 0; i < 5; i++) begin
      chk("t2_hold_op", {30'd0, sal_if.sal_op}, 32'd0);
      chk("t2_hold_valid", {31'd0, sal_if.sal_valid}, 32'd1);
      step();
    end
    sal_if.sal_ready = 1'b1;
    step();
    chk("t2_op1", {30'd0, sal_if.sal_op}, 32'd1);
    step();
    chk("t2_op3", {30'd0, sal_if.sal_op}, 32'd3);
    step();
    chk("t2_valid_drop", {31'd0, sal_if.sal_valid}, 32'd0);
    chk("t2_pend_clr", {28'd0, pend}, 32'd0);

    // Same-bit re-request on the grant edge
    exp_q.push_back(2'd1);
    exp_q.push_back(2'd1);
    req_op = 4'b0010;
    step();
    step();
    req_op = 4'b0000;
    chk("t3_op", {30'd0, sal_if.sal_op}, 32'd1);
    chk("t3_pend_kept", {28'd0, pend}, 32'h2);
    step();
    chk("t3_op_again", {30'd0, sal_if.sal_op}, 32'd1);
    chk("t3_valid_again", {31'd0, sal_if.sal_valid}, 32'd1);
    chk("t3_pend_clr", {28'd0, pend}, 32'd0);
    step();
    chk("t3_valid_drop", {31'd0, sal_if.sal_valid}, 32'd0);

    // Enable gating: offered code 3 survives en=0, request 0 is dropped
    sal_if.sal_ready = 1'b0;
    exp_q.push_back(2'd3);
    req_op = 4'b1000;
    step();
    req_op = 4'b0000;
    step();
    chk("t4_op", {30'd0, sal_if.sal_op}, 32'd3);
    en = 1'b0;
    req_op = 4'b0001;
    step();
    req_op = 4'b0000;
    repeat (3) step();
    chk("t4_hold_op", {30'd0, sal_if.sal_op}, 32'd3);
    chk("t4_hold_valid", {31'd0, sal_if.sal_valid}, 32'd1);
    chk("t4_pend", {28'd0, pend}, 32'd0);
    sal_if.sal_ready = 1'b1;
    step();
    chk("t4_valid_drop", {31'd0, sal_if.sal_valid}, 32'd0);
    en = 1'b1;
    repeat (3) step();
    chk("t4_no_req0", {31'd0, sal_if.sal_valid}, 32'd0);
    chk("t4_pend_after", {28'd0, pend}, 32'd0);

    // Multi-hot request: sticky error, both ops served
    exp_q.push_back(2'd2);
    exp_q.push_back(2'd3);
    req_op = 4'b1100;
    step();
    req_op = 4'b0000;
    chk("t5_err", {31'd0, err_multi}, 32'd1);
    chk("t5_pend", {28'd0, pend}, 32'hC);
    repeat (3) step();
    chk("t5_valid_drop", {31'd0, sal_if.sal_valid}, 32'd0);
    chk("t5_err_sticky", {31'd0, err_multi}, 32'd1);

    // Reset while a code is held
    sal_if.sal_ready = 1'b0;
    req_op = 4'b0100;
    step();
    req_op = 4'b0010;
    step();
    req_op = 4'b0000;
    chk("t5_held_valid", {31'd0, sal_if.sal_valid}, 32'd1);
    chk("t5_held_op", {30'd0, sal_if.sal_op}, 32'd2);
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("t5_rst_valid", {31'd0, sal_if.sal_valid}, 32'd0);
    chk("t5_rst_op", {30'd0, sal_if.sal_op}, 32'd0);
    chk("t5_rst_pend", {28'd0, pend}, 32'd0);
    chk("t5_rst_err", {31'd0, err_multi}, 32'd0);

    // All-ones refill: rotation with round robin, op 0 repeated otherwise
    sal_if.sal_ready = 1'b1;
`ifdef CODIFICADOR_ROUND_ROBIN_EN
    for (int i = 0; i < 11; i++) exp_q.push_back(2'(i % 4));
`else
    for (int i = 0; i < 8; i++) exp_q.push_back(2'd0);
    exp_q.push_back(2'd1);
    exp_q.push_back(2'd2);
    exp_q.push_back(2'd3);
`endif
    req_op = 4'b1111;
    repeat (8) step();
    req_op = 4'b0000;
    chk("t6_err", {31'd0, err_multi}, 32'd1);
    for (int i = 0; i < 40 && exp_q.size() != 0; i++) step();
    chk("drain_left", exp_q.size(), 32'd0);
    repeat (2) step();
    chk("t6_valid_drop", {31'd0, sal_if.sal_valid}, 32'd0);
    chk("t6_pend_clr", {28'd0, pend}, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
